// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampled frame decoder feeding a first-word-fall-through FIFO.
// Optional break detection is enabled with the UART_RX_MON_BREAK_DET_EN macro.
module uart_rx_monitor #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          uart_clk,
  input  logic                          nrst,
  input  logic                          rx_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef UART_RX_MON_BREAK_DET_EN
  ,
  output logic                          break_det
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

`ifdef UART_RX_MON_BREAK_DET_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic sync1_q;
  logic line;

  state_t           state_q, state_n;
  logic [TW-1:0]    tick_q, tick_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic             perr_q, perr_n;
  logic             ferr_q, ferr_n;
  logic             zero_q, zero_n;
  logic             armed_q, armed_n;
  logic             push_q, push_n;
  logic [EW-1:0]    entry_q, entry_n;
`ifdef UART_RX_MON_BREAK_DET_EN
  logic             brk_q, brk_n;
`endif

  logic             tick_hit;
  logic             stop_ferr;
  logic             stop_zero;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             overrun_q;
  logic             fifo_empty;
  logic             fifo_full;
  logic             do_push;
  logic             do_pop;
  logic [EW-1:0]    head;

  // Two-flop synchronizer; both stages reload the idle level on reset.
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      sync1_q <= 1'b1;
      line    <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      line    <= sync1_q;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      armed_q <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
`ifdef UART_RX_MON_BREAK_DET_EN
      brk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
      zero_q  <= zero_n;
      armed_q <= armed_n;
      push_q  <= push_n;
      entry_q <= entry_n;
`ifdef UART_RX_MON_BREAK_DET_EN
      brk_q   <= brk_n;
`endif
    end
  end

  // The start bit is sampled at its midpoint; every later bit one full bit period on.
  assign tick_hit  = (state_q == START) ? (tick_q == TICK_HALF) : (tick_q == TICK_LAST);
  assign stop_ferr = ferr_q | ~line;
  assign stop_zero = zero_q & ~line;

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    zero_n  = zero_q;
    armed_n = armed_q;
    push_n  = 1'b0;
    entry_n = entry_q;
`ifdef UART_RX_MON_BREAK_DET_EN
    brk_n   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (line) begin
          armed_n = 1'b1;
        end
        if (armed_q && !line) begin
          state_n = START;
          tick_n  = '0;
          armed_n = 1'b0;
        end
      end

      START: begin
        if (tick_hit) begin
          tick_n = '0;
          if (line) begin
            state_n = IDLE;
            armed_n = 1'b1;
          end else begin
            state_n = DATA;
            bit_n   = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
            zero_n  = 1'b1;
          end
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end

      DATA: begin
        if (tick_hit) begin
          tick_n  = '0;
          shift_n = {line, shift_q[DATA_BITS-1:1]};
          zero_n  = zero_q & ~line;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_q + BW'(1);
          end
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end

      PARITY: begin
        if (tick_hit) begin
          tick_n  = '0;
          bit_n   = '0;
          perr_n  = ((^shift_q) ^ line) != (PARITY_MODE == 1);
          zero_n  = zero_q & ~line;
          state_n = STOP;
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end

      STOP: begin
        if (tick_hit) begin
          tick_n = '0;
          if (bit_q == STOP_LAST) begin
            state_n = IDLE;
            // A low final stop bit leaves the decoder disarmed until the line idles high.
            armed_n = line;
            bit_n   = '0;
            if (BREAK_EN && stop_zero) begin
`ifdef UART_RX_MON_BREAK_DET_EN
              brk_n = 1'b1;
`endif
            end else begin
              push_n  = 1'b1;
              entry_n = {perr_q, stop_ferr, shift_q};
            end
          end else begin
            bit_n  = bit_q + BW'(1);
            ferr_n = stop_ferr;
            zero_n = stop_zero;
          end
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == COUNT_FULL);
  assign do_pop     = rd_en & ~fifo_empty;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push    = push_q & (~fifo_full | do_pop);

  always_ff @(posedge uart_clk) begin
    if (do_push) begin
      mem[wr_q] <= entry_q;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overrun_q <= push_q & fifo_full & ~do_pop;
    end
  end

  // Head fields are masked while empty so the outputs read zero after reset.
  assign head       = mem[rd_q];
  assign rx_valid   = ~fifo_empty;
  assign rx_data    = fifo_empty ? '0 : head[DATA_BITS-1:0];
  assign frame_err  = ~fifo_empty & head[DATA_BITS];
  assign parity_err = ~fifo_empty & head[DATA_BITS+1];
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_MON_BREAK_DET_EN
  assign break_det  = brk_q;
`endif

endmodule
